// File: rtl/router_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : router_fsm
//  Description : Packet sequencer for the 1x3 router. Tracks header, payload
//                and parity phases of each packet, issues per-cycle state
//                strobes to the register stage and output FIFO writes, and
//                stalls the source through busy while FIFOs drain.
//  Revision    : 1.0 - initial release
// ============================================================================
module router_fsm #(
    parameter int NUM_PORTS = 3
) (
    input  logic       router_clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        WAIT_TILL_EMPTY    = 3'd1,
        LOAD_FIRST_DATA    = 3'd2,
        LOAD_DATA          = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t     r_state;
    logic [1:0] r_addr;

    logic w_addr_ok;
    logic w_empty_live;
    logic w_empty_latched;
    logic w_soft_hit;

    // Header address is only usable if it names an existing output FIFO
    assign w_addr_ok = (32'(data_in) < NUM_PORTS);

    // Empty flag of the FIFO named by the incoming header byte
    always_comb begin
        w_empty_live = 1'b0;
        case (data_in)
            2'd0:    w_empty_live = fifo_empty_0;
            2'd1:    w_empty_live = fifo_empty_1;
            2'd2:    w_empty_live = fifo_empty_2;
            default: w_empty_live = 1'b0;
        endcase
    end

    // Empty flag and timeout of the FIFO owning the current packet
    always_comb begin
        w_empty_latched = 1'b0;
        w_soft_hit      = 1'b0;
        case (r_addr)
            2'd0: begin
                w_empty_latched = fifo_empty_0;
                w_soft_hit      = soft_reset_0;
            end
            2'd1: begin
                w_empty_latched = fifo_empty_1;
                w_soft_hit      = soft_reset_1;
            end
            2'd2: begin
                w_empty_latched = fifo_empty_2;
                w_soft_hit      = soft_reset_2;
            end
            default: begin
                w_empty_latched = 1'b0;
                w_soft_hit      = 1'b0;
            end
        endcase
    end

    // State register and address latch; a timeout on the owning FIFO aborts the packet
    always_ff @(posedge router_clock) begin
        if (reset) begin
            r_state <= DECODE_ADDRESS;
            r_addr  <= 2'b00;
        end else begin
            if (detect_add && pkt_valid) begin
                r_addr <= data_in;
            end
            if (w_soft_hit) begin
                r_state <= DECODE_ADDRESS;
            end else begin
                case (r_state)
                    DECODE_ADDRESS: begin
                        if (pkt_valid && w_addr_ok) begin
                            r_state <= w_empty_live ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                        end
                    end
                    WAIT_TILL_EMPTY: begin
                        if (w_empty_latched) begin
                            r_state <= LOAD_FIRST_DATA;
                        end
                    end
                    LOAD_FIRST_DATA: r_state <= LOAD_DATA;
                    LOAD_DATA: begin
                        if (fifo_full) begin
                            r_state <= FIFO_FULL_STATE;
                        end else if (!pkt_valid) begin
                            r_state <= LOAD_PARITY;
                        end
                    end
                    FIFO_FULL_STATE: begin
                        if (!fifo_full) begin
                            r_state <= LOAD_AFTER_FULL;
                        end
                    end
                    LOAD_AFTER_FULL: begin
                        if (parity_done) begin
                            r_state <= DECODE_ADDRESS;
                        end else if (low_pkt_valid) begin
                            r_state <= LOAD_PARITY;
                        end else begin
                            r_state <= LOAD_DATA;
                        end
                    end
                    LOAD_PARITY: r_state <= CHECK_PARITY_ERROR;
                    CHECK_PARITY_ERROR: begin
                        r_state <= fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                    end
                    default: r_state <= DECODE_ADDRESS;
                endcase
            end
        end
    end

    // Moore decodes of the registered state
    assign detect_add    = (r_state == DECODE_ADDRESS);
    assign lfd_state     = (r_state == LOAD_FIRST_DATA);
    assign ld_state      = (r_state == LOAD_DATA);
    assign laf_state     = (r_state == LOAD_AFTER_FULL);
    assign full_state    = (r_state == FIFO_FULL_STATE);
    assign rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
    assign write_enb_reg = (r_state == LOAD_DATA) || (r_state == LOAD_AFTER_FULL) ||
                           (r_state == LOAD_PARITY);
    assign busy          = !((r_state == DECODE_ADDRESS) || (r_state == LOAD_DATA));

endmodule
`default_nettype wire
